db_multi: RTL and testbench
===========================

Name: db_multi

Overview:
Multi-channel, parameterised switch debouncer for the board's push-buttons and slide switches. It replaces the single-channel fixed-depth debouncer. Each channel has an input synchroniser, a shared tick prescaler, a configurable stability count, and registered level outputs with single-cycle rise and fall pulses. Downstream logic (UART test control, mode select) consumes either the `db` level or the edge pulses directly.

Parameters:
- W, 4: number of independent channels.
- N, 19: prescaler width. A tick occurs every 2^N clocks (≈10 ms at 50 MHz).
- K, 3: consecutive ticks an input must hold its new value before `db` changes. Legal range is K ≥ 1.
- SYNC_STAGES, 2: flip-flops in each input synchroniser. Legal range is ≥ 2.

Ports:
- clk, input, 1: system clock, rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- sw, input, W: raw, bouncing, asynchronous switch inputs.
- db, output, W: debounced level per channel, registered.
- rise, output, W: one-clock pulse in the first cycle `db[i]` is 1.
- fall, output, W: one-clock pulse in the first cycle `db[i]` is 0.
- tick, output, 1: prescaler tick strobe, exported for reuse and for the testbench.

Behaviour:
- **Reset.** `reset` asynchronously clears the following:
  - prescaler q (N bits) to 0;
  - all synchroniser flops to 0;
  - all per-channel counters to 0;
  - `db`, `rise` and `fall` to all-0.
  - Reset asserted mid-count discards any partial progress. No pulse is produced on reset entry or exit.
- **Prescaler.**
  - q increments by 1 every clock and wraps modulo 2^N.
  - `tick` = (q == 0), combinational from q.
  - `tick` is therefore high in the first cycle after reset release, then every 2^N cycles.
- **Synchroniser.**
  - `s[i]` is `sw[i]` delayed by SYNC_STAGES flops.
  - All comparisons below use `s[i]` only. No metastable path reaches the counters.
- **Per-channel counter.**
  - Each channel i has a counter c[i] of width clog2(K+1), plus its `db[i]`.
  - Channels are fully independent. Simultaneous activity on several channels has no interaction.
  - The rules are evaluated per clock, in priority order:
    1. If `s[i]` == `db[i]`, then c[i] ← 0. A mismatch that disappears aborts the count, and this takes priority even in a tick cycle.
    2. Else if `tick` and c[i] == K-1:
       - `db[i]` ← `s[i]` and c[i] ← 0;
       - `rise[i]` ← `s[i]` and `fall[i]` ← ~`s[i]` for exactly one cycle.
    3. Else if `tick`, then c[i] ← c[i]+1.
    4. Else hold.
  - `rise` and `fall` are registered and return to 0 in the next cycle. They are never both 1 on the same channel.
- **Timing.**
  - `db[i]` changes in the cycle after the K-th tick observed while `s[i]` differs from `db[i]`.
  - Measured from a clean edge on `sw[i]`, the latency is between (K-1)·2^N + SYNC_STAGES + 1 and K·2^N + SYNC_STAGES + 1 clocks.
- **K = 1.** `db` follows `s` at the first tick of mismatch.
- **Counter width.** c[i] never exceeds K-1, so no overflow handling is needed.

Test Plan:
All scenarios use W=4, N=3, K=3, SYNC_STAGES=2. Cycle 0 is the first cycle after reset release, and ticks occur at cycles 0, 8, 16, 24, 32, …

- **Clean press.** `sw[0]` goes 0→1 at cycle 10, so `s[0]` is high from cycle 12.
  - Ticks at 16, 24 and 32 count.
  - `db[0]`=1 from cycle 33; `rise[0]`=1 in cycle 33 only.
  - Other channels stay 0 throughout.
- **Glitch rejection.** `sw[1]` is 1 for cycles 10–19 only.
  - `db[1]`, `rise[1]` and `fall[1]` stay 0 through cycle 100.
- **Bounce then settle.** `sw[2]` toggles every 3 clocks from cycle 10 to 49, then holds 1.
  - Exactly one `rise[2]` pulse, no `fall[2]`.
  - `db[2]`=1 no earlier than cycle 49 + 2 + 2·8.
- **Release.** `db[0]`=1 is steady, then `sw[0]` goes 1→0 on the cycle after a tick.
  - `db[0]` falls after the third subsequent tick.
  - `fall[0]` is high for one cycle.
- **Reset mid-count.** `sw[3]`=1 and two ticks have been counted; assert `reset` for 1 clock.
  - All outputs are 0 immediately.
  - After release with `sw[3]` still 1, `db[3]` rises only after 3 fresh ticks from the new cycle 2.
- **Simultaneous channels.** `sw[3:0]` goes 0000→1111 at cycle 10.
  - `db` goes 1111 and `rise`=1111 together in cycle 33.

Source files
------------

// File: rtl/db_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, shared tick prescaler,
// K-tick stability counter, registered level plus single-cycle rise/fall pulses.
module db_multi #(
  parameter int W           = 4,
  parameter int N           = 19,
  parameter int K           = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw,
  output logic [W-1:0] db,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  output logic         tick
);

  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] C_LAST = CW'(K - 1);

  logic [N-1:0]                 r_q;
  logic [SYNC_STAGES-1:0][W-1:0] r_sync;
  logic [W-1:0][CW-1:0]         r_cnt;
  logic [W-1:0][CW-1:0]         w_cnt_nxt;
  logic [W-1:0]                 r_db, r_rise, r_fall;
  logic [W-1:0]                 w_db_nxt, w_rise_nxt, w_fall_nxt;
  logic [W-1:0]                 w_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_sync <= '0;
    end else begin
      r_q    <= r_q + N'(1);
      r_sync <= {r_sync[SYNC_STAGES-2:0], sw};
    end
  end

  assign tick = (r_q == '0);
  assign w_s  = r_sync[SYNC_STAGES-1];

  // A match with db always clears the count first, so a vanishing mismatch aborts even on a tick.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_db_nxt   = r_db;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (w_s[i] == r_db[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (tick && (r_cnt[i] == C_LAST)) begin
        w_db_nxt[i]   = w_s[i];
        w_cnt_nxt[i]  = '0;
        w_rise_nxt[i] = w_s[i];
        w_fall_nxt[i] = ~w_s[i];
      end else if (tick) begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_db   <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_db   <= w_db_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign db   = r_db;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: tb/tb_db_multi.sv
// Scoreboard bench for db_multi: a cycle-indexed reference model predicts {db,rise,fall,tick}
// each cycle from the stimulus history; a negedge monitor pops and compares.
module tb_db_multi;

  localparam int W    = 4;
  localparam int N    = 3;
  localparam int K    = 3;
  localparam int SYNC = 2;
  localparam int P    = 1 << N;
  localparam int OW   = 3 * W + 1;

  typedef struct {
    int          c;
    logic [OW-1:0] v;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw;
  logic [W-1:0] db, rise, fall;
  logic         tick;

  db_multi #(.W(W), .N(N), .K(K), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw),
    .db   (db),
    .rise (rise),
    .fall (fall),
    .tick (tick)
  );

  always #5 clk = ~clk;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  // Reference model: cycle number since reset release, sw history, and per-channel mismatch run start.
  int           cyc;
  logic [W-1:0] sw_hist [0:4095];
  logic [W-1:0] m_db, m_rise, m_fall;
  int           run_start [W];
  logic [W-1:0] cur;

  function automatic int ticks_in(input int m, input int c);
    return c / P - (m + P - 1) / P + 1;
  endfunction

  task automatic model_clear();
    cyc    = 0;
    m_db   = '0;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) run_start[i] = -1;
  endtask

  // Called at 2 time units after a rising edge: predicts this cycle, drives sw, advances one clock.
  task automatic step(input logic [W-1:0] v);
    exp_t         e;
    logic         t;
    logic         s;
    logic [W-1:0] nd, nr, nf;
    t   = ((cyc % P) == 0);
    e.c = cyc;
    e.v = {m_db, m_rise, m_fall, t};
    exp_q.push_back(e);
    sw           = v;
    sw_hist[cyc] = v;
    nd = m_db;
    nr = '0;
    nf = '0;
    for (int i = 0; i < W; i++) begin
      s = (cyc >= SYNC) ? sw_hist[cyc - SYNC][i] : 1'b0;
      if (s == m_db[i]) begin
        run_start[i] = -1;
      end else begin
        if (run_start[i] < 0) run_start[i] = cyc;
        if (t && ticks_in(run_start[i], cyc) == K) begin
          nd[i] = s;
          nr[i] = s;
          nf[i] = ~s;
          run_start[i] = -1;
        end
      end
    end
    m_db   = nd;
    m_rise = nr;
    m_fall = nf;
    cyc++;
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step(cur);
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    #1;
    e.c = -1;
    e.v = {{(3 * W){1'b0}}, 1'b1};
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  always @(negedge clk) begin
    exp_t         e;
    logic [OW-1:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {db, rise, fall, tick};
      n_checks++;
      if (got !== e.v)
        begin
          n_fail++;
          $display("FAIL outputs cyc=%0d: got db=%b rise=%b fall=%b tick=%b, want db=%b rise=%b fall=%b tick=%b",
                   e.c, got[OW-1 -: W], got[2*W -: W], got[W -: W], got[0],
                   e.v[OW-1 -: W], e.v[2*W -: W], e.v[W -: W], e.v[0]);
        end
    end
  end

  initial begin
    logic [W-1:0] v;
    int           mode [W];
    reset = 1'b1;
    sw    = '0;
    cur   = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    model_clear();

    // Press on ch0, glitch on ch1, bounce on ch2, ch3 idle.
    for (int c = 0; c < 120; c++) begin
      v = '0;
      if (c >= 10) v[0] = 1'b1;
      if (c >= 10 && c <= 19) v[1] = 1'b1;
      if (c >= 10 && c <= 49) v[2] = (((c - 10) / 3) % 2) == 0;
      else if (c > 49) v[2] = 1'b1;
      cur = v;
      step(v);
    end

    // Release ch0 on the cycle after a tick.
    while ((cyc % P) != 1) hold(1);
    cur[0] = 1'b0;
    hold(40);

    // Reset after two ticks counted on ch3, then re-count from scratch.
    while ((cyc % P) != 1) hold(1);
    cur[3] = 1'b1;
    hold(17);
    do_reset();
    hold(40);

    // All channels together.
    cur = '0;
    do_reset();
    hold(10);
    cur = '1;
    hold(40);

    // Random: per-channel quiet/bouncy phases, with a reset between segments.
    for (int seg = 0; seg < 4; seg++) begin
      for (int k = 0; k < 600; k++) begin
        if ((k % 48) == 0)
          for (int i = 0; i < W; i++) mode[i] = int'($urandom_range(0, 2));
        for (int i = 0; i < W; i++) begin
          if (mode[i] == 0) begin
            if ($urandom_range(0, 99) < 1) cur[i] = ~cur[i];
          end else if (mode[i] == 1) begin
            if ($urandom_range(0, 99) < 30) cur[i] = ~cur[i];
          end else begin
            if ($urandom_range(0, 99) < 6) cur[i] = ~cur[i];
          end
        end
        step(cur);
      end
      do_reset();
    end
    hold(5);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
